// File: rtl/arb_defs_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and default sizing.
package arb_defs;

  localparam int ARB_N        = 8;
  localparam int ARB_W        = 3;
  localparam int ARB_HOLD_MAX = 15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: returns the first set request at or after ptr, in circular order.
module rr_prio_enc
  import arb_defs::*;
#(
  parameter int N = ARB_N,
  parameter int W = ARB_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         ena,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [N-1:0] rot_s;
  logic [W-1:0] off_s;

  // Rotate right by ptr so the highest-priority requester lands on bit 0.
  always_comb begin
    rot_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      rot_s[i] = req[W'(i) + ptr];
    end
  end

  // Lowest set bit of the rotated vector; scanning downward lets the lowest index win.
  always_comb begin
    off_s = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = W'(i);
      end else begin
        off_s = off_s;
      end
    end
  end

  assign any = ena & (|rot_s);
  assign idx = off_s + ptr;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with a registered, held grant passed on in circular order.
// Define ARB_TIMEOUT_EN to add a hold counter that forces release after HOLD_MAX cycles.
module rr_arbiter8
  import arb_defs::*;
#(
  parameter int N        = ARB_N,
  parameter int W        = ARB_W,
  parameter int HOLD_MAX = ARB_HOLD_MAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld,
  output logic         tmo
);

  if (N < 2 || N > 8 || (1 << W) != N || HOLD_MAX < 1) begin : g_param_check
    $error("rr_arbiter8: unsupported N/W/HOLD_MAX combination");
  end

  arb_state_e   state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [W-1:0] gnt_idx_q, gnt_idx_d;
  logic         gnt_vld_q, gnt_vld_d;
  logic         tmo_q, tmo_d;

  logic         owner_req_s;
  logic         normal_rel_s;
  logic         forced_s;
  logic         release_s;
  logic         timeout_hit_s;
  logic [N-1:0] enc_req_s;
  logic [W-1:0] enc_ptr_s;
  logic         enc_ena_s;
  logic [W-1:0] enc_idx_s;
  logic         enc_any_s;
  logic [N-1:0] enc_onehot_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);

  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  // Counter value seen in the k-th grant cycle is k-1, so this fires in cycle HOLD_MAX.
  assign timeout_hit_s = (hold_cnt_q == CW'(HOLD_MAX - 1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Release detection and encoder setup; on release the owner is masked and ptr moves past it.
  always_comb begin
    owner_req_s  = req[gnt_idx_q];
    normal_rel_s = 1'b0;
    forced_s     = 1'b0;
    release_s    = 1'b0;
    enc_req_s    = req;
    enc_ptr_s    = ptr_q;
    enc_ena_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        enc_ena_s = 1'b1;
      end
      ST_GRANT: begin
        normal_rel_s = done | ~owner_req_s;
        forced_s     = timeout_hit_s & ~normal_rel_s;
        release_s    = normal_rel_s | forced_s;
        enc_req_s    = req & ~gnt_q;
        enc_ptr_s    = gnt_idx_q + W'(1);
        enc_ena_s    = release_s;
      end
      default: begin
        enc_ena_s = 1'b0;
      end
    endcase
  end

  rr_prio_enc #(
    .N (N),
    .W (W)
  ) u_enc (
    .req (enc_req_s),
    .ptr (enc_ptr_s),
    .ena (enc_ena_s),
    .idx (enc_idx_s),
    .any (enc_any_s)
  );

  assign enc_onehot_s = {{(N-1){1'b0}}, 1'b1} << enc_idx_s;

  // Next-state and next-grant decision.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    tmo_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = (state_q == ST_GRANT) ? hold_cnt_q + CW'(1) : hold_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enc_any_s) begin
          state_d   = ST_GRANT;
          gnt_d     = enc_onehot_s;
          gnt_idx_d = enc_idx_s;
          gnt_vld_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = {CW{1'b0}};
`endif
        end else begin
          gnt_d     = {N{1'b0}};
          gnt_vld_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          ptr_d = enc_ptr_s;
          tmo_d = forced_s;
          if (enc_any_s) begin
            gnt_d     = enc_onehot_s;
            gnt_idx_d = enc_idx_s;
            gnt_vld_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_d = {CW{1'b0}};
`endif
          end else begin
            state_d   = ST_IDLE;
            gnt_d     = {N{1'b0}};
            gnt_vld_d = 1'b0;
          end
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gnt_d     = {N{1'b0}};
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= {W{1'b0}};
      gnt_q     <= {N{1'b0}};
      gnt_idx_q <= {W{1'b0}};
      gnt_vld_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      tmo_q     <= tmo_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Grant hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= {CW{1'b0}};
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign tmo     = tmo_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed vector table, hand sequences, and random
// stimulus against a queue-free behavioural round-robin model.
module tb_rr_arbiter8;

  localparam int N  = 8;
  localparam int W  = 3;
  localparam int HM = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic         gnt_vld;
  logic         tmo;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
  } vec_t;

  vec_t tbl [22];

  // Behavioural model: owner index (-1 = none), priority pointer, cycles the grant has been visible.
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_tmo;

  rr_arbiter8 #(
    .N        (N),
    .W        (W),
    .HOLD_MAX (HM)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .tmo     (tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                           input logic e_vld, input logic e_tmo);
    check({name, "_gnt"}, 32'(gnt), 32'(e_gnt));
    check({name, "_vld"}, 32'(gnt_vld), 32'(e_vld));
    check({name, "_tmo"}, 32'(tmo), 32'(e_tmo));
    if (e_vld) begin
      check({name, "_idx"}, 32'(gnt_idx), 32'(e_idx));
    end
  endtask

  task automatic drive(input logic r_rst, input logic [7:0] r_req, input logic r_done);
    rst  = r_rst;
    req  = r_req;
    done = r_done;
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [7:0] r, input int p, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] r, input logic d, input logic rs);
    bit rel;
    bit forced;
    m_tmo = 1'b0;
    if (rs) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      m_owner = pick(r, m_ptr, -1);
      m_held  = (m_owner >= 0) ? 1 : 0;
    end else begin
      rel    = d || !r[m_owner];
      forced = 1'b0;
`ifdef ARB_TIMEOUT_EN
      forced = !rel && (m_held == HM);
`endif
      if (rel || forced) begin
        m_tmo   = forced;
        m_ptr   = (m_owner + 1) % N;
        m_owner = pick(r, m_ptr, m_owner);
        m_held  = (m_owner >= 0) ? 1 : 0;
      end else begin
        m_held++;
      end
    end
  endtask

  initial begin
    logic [7:0] e_gnt;
    logic [7:0] r;
    logic       d;
    logic       rs;

    tbl[0]  = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1};
    tbl[1]  = '{8'h81, 1'b1, 8'h80, 3'd7, 1'b1};
    tbl[2]  = '{8'h81, 1'b1, 8'h01, 3'd0, 1'b1};
    tbl[3]  = '{8'hFF, 1'b1, 8'h02, 3'd1, 1'b1};
    tbl[4]  = '{8'hFF, 1'b1, 8'h04, 3'd2, 1'b1};
    tbl[5]  = '{8'hFF, 1'b1, 8'h08, 3'd3, 1'b1};
    tbl[6]  = '{8'hFF, 1'b1, 8'h10, 3'd4, 1'b1};
    tbl[7]  = '{8'hFF, 1'b1, 8'h20, 3'd5, 1'b1};
    tbl[8]  = '{8'hFF, 1'b1, 8'h40, 3'd6, 1'b1};
    tbl[9]  = '{8'hFF, 1'b1, 8'h80, 3'd7, 1'b1};
    tbl[10] = '{8'hFF, 1'b1, 8'h01, 3'd0, 1'b1};
    tbl[11] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[12] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1};
    tbl[13] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1};
    tbl[14] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[15] = '{8'h28, 1'b0, 8'h20, 3'd5, 1'b1};
    tbl[16] = '{8'h21, 1'b0, 8'h20, 3'd5, 1'b1};
    tbl[17] = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b1};
    tbl[18] = '{8'h24, 1'b1, 8'h04, 3'd2, 1'b1};
    tbl[19] = '{8'h04, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[20] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[21] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1};

    // Reset and idle
    drive(1'b1, 8'h00, 1'b0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    check_out("rst", 8'h00, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      check_out($sformatf("idle%0d", i), 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // Directed table: basic grant, wrap, rotation, owner drop, done with req high, single requester
    for (int i = 0; i < 22; i++) begin
      drive(1'b0, tbl[i].req, tbl[i].done);
      check_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].vld, 1'b0);
    end

    // Reset during an idx=5 grant, then priority restarts from 0
    drive(1'b0, 8'h20, 1'b1);
    check_out("pre_rst", 8'h20, 3'd5, 1'b1, 1'b0);
    drive(1'b1, 8'h20, 1'b0);
    check("midrst_idx", 32'(gnt_idx), 32'd0);
    check_out("midrst", 8'h00, 3'd0, 1'b0, 1'b0);
    drive(1'b0, 8'h21, 1'b0);
    check_out("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);

    // Hold behaviour with no done
    drive(1'b1, 8'h00, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < HM; i++) begin
      drive(1'b0, 8'h06, 1'b0);
      check_out($sformatf("hold%0d", i), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    drive(1'b0, 8'h06, 1'b0);
    check_out("tmo_fire", 8'h04, 3'd2, 1'b1, 1'b1);
    drive(1'b0, 8'h06, 1'b0);
    check_out("tmo_after", 8'h04, 3'd2, 1'b1, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 8'h06, 1'b0);
      check_out($sformatf("hold%0d", i), 8'h02, 3'd1, 1'b1, 1'b0);
    end
`endif

    // Random stimulus against the model
    model_step(8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h00, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      rs = ($urandom_range(99) == 0);
      r  = 8'($urandom);
      if ($urandom_range(2) == 0) r = r & 8'($urandom);
      d  = ($urandom_range(3) == 0);
      model_step(r, d, rs);
      drive(rs, r, d);
      e_gnt = 8'h00;
      if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
      check_out($sformatf("rnd%0d", c), e_gnt, 3'(m_owner), (m_owner >= 0), m_tmo);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
